// File: rtl/object_collision_scanner.sv
// object_collision_scanner
//   Walks the packed object table one slot per clock and tests each enabled,
//   non-empty object against a single self box. Contact flags OR-accumulate
//   over the scan. A per-slot hit bitmap is built. The type of the
//   lowest-index hit slot is kept. All results are published together with
//   a one-cycle done pulse.
// Ports
//   clk, rst     clock; asynchronous active-high reset
//   start        1-cycle pulse that begins a scan (ignored unless idle)
//   self_coord   {X,Y} of the self box, latched on the starting edge
//   self_size    {W,H} of the self box, latched on the starting edge
//   obj_coord    packed {X,Y} per slot, slot i at [i*32+:32]
//   obj_size     packed {W,H} per slot, slot i at [i*32+:32]
//   obj_type     packed 10-bit type per slot, slot i at [i*10+:10]
//   obj_enable   per-slot collide enable
//   busy         high while slots are being scanned
//   done         1-cycle pulse when the outputs below update
//   collision    {up,down,left,right}
//   hit_map      bit i set when slot i touched on any side
//   hit_type     type of the lowest-index hit slot, 0 when nothing was hit
module object_collision_scanner #(
  parameter int N_OBJ = 20,
  parameter int TOL   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [31:0]          self_coord,
  input  logic [31:0]          self_size,
  input  logic [32*N_OBJ-1:0]  obj_coord,
  input  logic [32*N_OBJ-1:0]  obj_size,
  input  logic [10*N_OBJ-1:0]  obj_type,
  input  logic [N_OBJ-1:0]     obj_enable,
  output logic                 busy,
  output logic                 done,
  output logic [3:0]           collision,
  output logic [N_OBJ-1:0]     hit_map,
  output logic [9:0]           hit_type
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [16:0]      TOL17    = 17'(TOL);
  localparam logic [4:0]       LAST_IDX = 5'(N_OBJ - 1);
  localparam logic [N_OBJ-1:0] ONE_BIT  = N_OBJ'(32'd1);

  // Edge sums are kept in 17 bits so a box touching 65535 cannot wrap.
  // The up/left lower bounds are written as "edge <= self + TOL" so that
  // a far edge smaller than TOL clamps to 0 without any subtraction.
  function automatic logic [3:0] contact_flags(
    input logic [31:0] s_c,
    input logic [31:0] s_z,
    input logic [31:0] o_c,
    input logic [31:0] o_z
  );
    logic [16:0] sx, sy, s_rt, s_bt;
    logic [16:0] ox, oy, o_rt, o_bt;
    logic        xov, yov, up, down, left, right;
    sx    = {1'b0, s_c[31:16]};
    sy    = {1'b0, s_c[15:0]};
    s_rt  = sx + {1'b0, s_z[31:16]};
    s_bt  = sy + {1'b0, s_z[15:0]};
    ox    = {1'b0, o_c[31:16]};
    oy    = {1'b0, o_c[15:0]};
    o_rt  = ox + {1'b0, o_z[31:16]};
    o_bt  = oy + {1'b0, o_z[15:0]};
    xov   = (sx < o_rt) && (ox < s_rt);
    yov   = (sy < o_bt) && (oy < s_bt);
    down  = xov && (oy <= s_bt) && (s_bt <= oy + TOL17);
    up    = xov && (o_bt <= sy + TOL17) && (sy <= o_bt);
    right = yov && (ox <= s_rt) && (s_rt <= ox + TOL17);
    left  = yov && (o_rt <= sx + TOL17) && (sx <= o_rt);
    return {up, down, left, right};
  endfunction

  state_t             state_r, state_s;
  logic [4:0]         idx_r;
  logic [31:0]        self_coord_r, self_size_r;
  logic [3:0]         acc_coll_r;
  logic [N_OBJ-1:0]   acc_map_r;
  logic [9:0]         acc_type_r;
  logic               acc_found_r;
  logic               busy_r, done_r;
  logic [3:0]         coll_r;
  logic [N_OBJ-1:0]   map_r;
  logic [9:0]         type_r;

  logic               last_s;
  logic [31:0]        slot_coord_s, slot_size_s;
  logic [9:0]         slot_type_s;
  logic               slot_valid_s;
  logic [3:0]         flags_s;
  logic               hit_s;

  assign last_s = (idx_r == LAST_IDX);

  // Select the slot under evaluation and derive its contact flags.
  always_comb begin
    slot_coord_s = obj_coord[32*int'(idx_r) +: 32];
    slot_size_s  = obj_size[32*int'(idx_r) +: 32];
    slot_type_s  = obj_type[10*int'(idx_r) +: 10];
    slot_valid_s = obj_enable[idx_r] && (slot_size_s[31:16] != 16'd0) &&
                   (slot_size_s[15:0] != 16'd0);
    if (slot_valid_s) begin
      flags_s = contact_flags(self_coord_r, self_size_r, slot_coord_s, slot_size_s);
    end else begin
      flags_s = 4'b0000;
    end
    hit_s = (flags_s != 4'b0000);
  end

  // Next-state logic for the scan sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = SCAN;
        end else begin
          state_s = IDLE;
        end
      end
      SCAN: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = SCAN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register plus registered busy, which tracks the SCAN state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == SCAN);
    end
  end

  // Self latch, slot index and working accumulators.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r        <= 5'd0;
      self_coord_r <= 32'd0;
      self_size_r  <= 32'd0;
      acc_coll_r   <= 4'b0000;
      acc_map_r    <= '0;
      acc_type_r   <= 10'd0;
      acc_found_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            idx_r        <= 5'd0;
            self_coord_r <= self_coord;
            self_size_r  <= self_size;
            acc_coll_r   <= 4'b0000;
            acc_map_r    <= '0;
            acc_type_r   <= 10'd0;
            acc_found_r  <= 1'b0;
          end
        end
        SCAN: begin
          acc_coll_r <= acc_coll_r | flags_s;
          if (hit_s) begin
            acc_map_r <= acc_map_r | (ONE_BIT << idx_r);
          end
          // Only the first hit in scan order names the collision type.
          if (hit_s && !acc_found_r) begin
            acc_type_r  <= slot_type_s;
            acc_found_r <= 1'b1;
          end
          idx_r <= last_s ? 5'd0 : idx_r + 5'd1;
        end
        default: begin
          idx_r <= 5'd0;
        end
      endcase
    end
  end

  // Published results change only in DONE, so partial scans never show.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_r <= 1'b0;
      coll_r <= 4'b0000;
      map_r  <= '0;
      type_r <= 10'd0;
    end else if (state_r == DONE) begin
      done_r <= 1'b1;
      coll_r <= acc_coll_r;
      map_r  <= acc_map_r;
      type_r <= acc_type_r;
    end else begin
      done_r <= 1'b0;
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign collision = coll_r;
  assign hit_map   = map_r;
  assign hit_type  = type_r;

endmodule
